// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : ALU operation codes, MIPS opcode/funct constants, decode bundle
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int XLEN   = 32;
    localparam int RIDX_W = 5;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    typedef struct packed {
        logic [XLEN-1:0]   a;
        logic [XLEN-1:0]   b;
        logic [3:0]        ctrl;
        logic [RIDX_W-1:0] dst;
        logic              reg_write;
        logic              illegal;
    } dec_t;

    function automatic logic [XLEN-1:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic logic [XLEN-1:0] zext16(input logic [15:0] imm);
        return {16'b0, imm};
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_stage_if
// Description : ID->EX issue handshake and operand bus
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_issue_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic              flush;
    logic              id_valid;
    logic              id_ready;
    logic [5:0]        id_opcode;
    logic [5:0]        id_funct;
    logic [4:0]        id_shamt;
    logic [15:0]       id_imm;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [REG_W-1:0]  id_rt;
    logic [REG_W-1:0]  id_rd;
    logic              ex_ready;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_A;
    logic [DATA_W-1:0] ex_B;
    logic [3:0]        ex_alu_control;
    logic [REG_W-1:0]  ex_dst;
    logic              ex_reg_write;
    logic              ex_illegal;

    modport master (
        output flush, id_valid, id_opcode, id_funct, id_shamt, id_imm,
               id_rs_data, id_rt_data, id_rt, id_rd, ex_ready,
        input  id_ready, ex_valid, ex_A, ex_B, ex_alu_control, ex_dst,
               ex_reg_write, ex_illegal
    );

    modport slave (
        input  flush, id_valid, id_opcode, id_funct, id_shamt, id_imm,
               id_rs_data, id_rt_data, id_rt, id_rd, ex_ready,
        output id_ready, ex_valid, ex_A, ex_B, ex_alu_control, ex_dst,
               ex_reg_write, ex_illegal
    );
endinterface
`default_nettype wire

// File: rtl/alu_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_decode
// Description : Combinational MIPS opcode/funct decode into ALU operands
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decode
    import alu_pkg::*;
(
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [4:0]        shamt,
    input  logic [15:0]       imm,
    input  logic [XLEN-1:0]   rs_data,
    input  logic [XLEN-1:0]   rt_data,
    input  logic [RIDX_W-1:0] rt,
    input  logic [RIDX_W-1:0] rd,
    output dec_t              dec
);

    always_comb begin
        // Fallback is the illegal encoding: ADD of rs/rt with no writeback
        dec           = '0;
        dec.a         = rs_data;
        dec.b         = rt_data;
        dec.ctrl      = ALU_ADD;
        dec.dst       = rt;
        dec.reg_write = 1'b0;
        dec.illegal   = 1'b1;
        if (opcode == OP_RTYPE) begin
            dec.dst       = rd;
            dec.reg_write = 1'b1;
            dec.illegal   = 1'b0;
            case (funct)
                FN_SLL:           begin dec.a = {27'b0, shamt}; dec.ctrl = ALU_SLL; end
                FN_SRL:           begin dec.a = {27'b0, shamt}; dec.ctrl = ALU_SRL; end
                FN_SLLV:          dec.ctrl = ALU_SLL;
                FN_SRLV:          dec.ctrl = ALU_SRL;
                FN_ADD, FN_ADDU:  dec.ctrl = ALU_ADD;
                FN_SUB, FN_SUBU:  dec.ctrl = ALU_SUB;
                FN_AND:           dec.ctrl = ALU_AND;
                FN_OR:            dec.ctrl = ALU_OR;
                FN_XOR:           dec.ctrl = ALU_XOR;
                FN_NOR:           dec.ctrl = ALU_NOR;
                FN_SLT:           dec.ctrl = ALU_SLT;
                default: begin
                    dec.reg_write = 1'b0;
                    dec.illegal   = 1'b1;
                end
            endcase
        end else begin
            dec.illegal = 1'b0;
            case (opcode)
                OP_ADDI, OP_ADDIU: begin dec.b = sext16(imm); dec.reg_write = 1'b1; end
                OP_SLTI: begin dec.b = sext16(imm); dec.ctrl = ALU_SLT; dec.reg_write = 1'b1; end
                OP_ANDI: begin dec.b = zext16(imm); dec.ctrl = ALU_AND; dec.reg_write = 1'b1; end
                OP_ORI:  begin dec.b = zext16(imm); dec.ctrl = ALU_OR;  dec.reg_write = 1'b1; end
                OP_XORI: begin dec.b = zext16(imm); dec.ctrl = ALU_XOR; dec.reg_write = 1'b1; end
                // lui is issued as imm << 16 so the ALU needs no dedicated op
                OP_LUI: begin
                    dec.a         = 32'd16;
                    dec.b         = zext16(imm);
                    dec.ctrl      = ALU_SLL;
                    dec.reg_write = 1'b1;
                end
                OP_LW:          begin dec.b = sext16(imm); dec.reg_write = 1'b1; end
                OP_SW:          dec.b = sext16(imm);
                OP_BEQ, OP_BNE: dec.ctrl = ALU_SUB;
                default:        dec.illegal = 1'b1;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_stage
// Description : ID->EX issue register with valid/ready, stall and flush
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_issue_stage_if.slave   bus
);

    dec_t              w_dec;
    logic              r_valid;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [3:0]        r_ctrl;
    logic [REG_W-1:0]  r_dst;
    logic              r_reg_write;
    logic              r_illegal;

    alu_decode u_decode (
        .opcode  (bus.id_opcode),
        .funct   (bus.id_funct),
        .shamt   (bus.id_shamt),
        .imm     (bus.id_imm),
        .rs_data (bus.id_rs_data),
        .rt_data (bus.id_rt_data),
        .rt      (bus.id_rt),
        .rd      (bus.id_rd),
        .dec     (w_dec)
    );

    // Readiness ignores flush: a flushed cycle still reports the slot as open
    assign bus.id_ready = !r_valid || bus.ex_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_ctrl      <= ALU_AND;
            r_dst       <= '0;
            r_reg_write <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (bus.flush) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
        end else if (bus.id_ready) begin
            r_valid <= bus.id_valid;
            if (bus.id_valid) begin
                r_a         <= w_dec.a;
                r_b         <= w_dec.b;
                r_ctrl      <= w_dec.ctrl;
                r_dst       <= w_dec.dst;
                r_reg_write <= w_dec.reg_write;
                r_illegal   <= w_dec.illegal;
            end
        end
    end

    assign bus.ex_valid       = r_valid;
    assign bus.ex_A           = r_a;
    assign bus.ex_B           = r_b;
    assign bus.ex_alu_control = r_ctrl;
    assign bus.ex_dst         = r_dst;
    assign bus.ex_reg_write   = r_reg_write;
    assign bus.ex_illegal     = r_illegal;

endmodule
`default_nettype wire
